vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Upstream pixel-timing stage for the VGA output path. Replaces the separate horizontal and vertical counters with one parameterised, resettable generator.
- Produces the 16-bit H/V count values, sync pulses, active-video flag, active-area pixel coordinates and line/frame strobes.
- Downstream colour and sync logic consumes these outputs.
- Counts advance on a pixel-enable, so the block runs either on the 25 MHz pixel clock (en tied high) or on a faster clock with a divided enable.

Parameters:
- H_SYNC, 96, horizontal sync width in pixels
- H_BP, 48, horizontal back porch
- H_ACTIVE, 640, horizontal active pixels
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vertical sync width in lines
- V_BP, 33, vertical back porch
- V_ACTIVE, 480, vertical active lines
- V_FP, 10, vertical front porch
- SYNC_POL, 1, level driven on hsync/vsync during the sync interval; the opposite level is driven elsewhere

Ports:
- clk  in  1  clock; pixel clock or faster
- rst_n  in  1  synchronous active-low reset
- en  in  1  pixel enable; counters advance only when high
- h_count  out  16  horizontal count, 0..H_TOTAL-1
- v_count  out  16  vertical count, 0..V_TOTAL-1
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- active  out  1  high inside the visible area
- pixel_x  out  10  active-area column, 0..H_ACTIVE-1; 0 when inactive
- pixel_y  out  10  active-area row, 0..V_ACTIVE-1; 0 when inactive
- line_start  out  1  one-clk strobe on entry to h_count=0
- frame_start  out  1  one-clk strobe on entry to (h_count,v_count)=(0,0)

Behaviour:
- Derived constants: H_TOTAL = sum of the four H_* parameters (800); V_TOTAL = sum of the four V_* parameters (525); HA0 = H_SYNC+H_BP (144); VA0 = V_SYNC+V_BP (35).
- Line order is sync, back porch, active, front porch, starting at count 0.
- All outputs are registered. Every decoded output corresponds to the h_count/v_count value presented in the same cycle, i.e. it is decoded from the next-count value. There is no skew between counts and decodes.
- Reset: sampled on the clk edge while rst_n=0. Then h_count=0, v_count=0, hsync=vsync=SYNC_POL, active=0, pixel_x=pixel_y=0, line_start=frame_start=0.
  - Reset has priority over en and applies mid-frame with no partial completion.
  - No strobe fires for the post-reset (0,0) position.
- Counting on a clk edge with en=1:
  - If h_count=H_TOTAL-1: h_count←0 and v_count steps; otherwise h_count←h_count+1.
  - v_count steps to (v_count=V_TOTAL-1) ? 0 : v_count+1.
- With en=0, all counts and level outputs hold, and both strobes are 0.
- Decodes, with h and v being the new count values:
  - hsync=SYNC_POL iff h<H_SYNC.
  - vsync=SYNC_POL iff v<V_SYNC.
  - active=1 iff HA0≤h<HA0+H_ACTIVE and VA0≤v<VA0+V_ACTIVE.
  - pixel_x=h-HA0 and pixel_y=v-VA0, truncated to 10 bits, when active; 0 otherwise.
- line_start=1 for exactly the one clk cycle following an en-qualified transition into h=0. frame_start additionally requires v=0. Both return to 0 on the next clk edge regardless of en.
- Arithmetic: counts are unsigned 16-bit. Comparisons are unsigned against constants. No count value ≥ H_TOTAL or ≥ V_TOTAL is ever produced.
- Parameter legality: H_TOTAL and V_TOTAL must each be ≤ 65535; H_ACTIVE and V_ACTIVE must each be ≤ 1024. Behaviour is undefined otherwise.

Test Plan:
- Reset: hold rst_n=0 for 5 clk with en=1 → h=v=0, hsync=vsync=1, active=0, strobes 0. Release, then 1 clk → h=1, v=0, no strobe.
- Horizontal timing, default params, en=1: hsync high for exactly 96 clk per line (h=0..95). Across one active line, active rises at h=144 with pixel_x=0 and falls at h=784 (pixel_x=639 at h=783). pixel_y=0 at v=35.
- Line wrap: at h=799, v=10, one en clk → h=0, v=11, line_start=1 for 1 clk, frame_start=0.
- Frame wrap: at h=799, v=524, one en clk → (0,0), line_start=frame_start=1 for 1 clk. vsync high for v=0..1 only. Frame period is 420000 en cycles.
- Enable gating: en toggles 1,0,0,1 starting at h=799, v=0 → h holds at 799 while en=0. line_start pulses only in the single clk after the en-qualified wrap, never for longer.
- Mid-frame reset and alternate params: assert rst_n=0 at h=300, v=200 → next clk all reset values. Then SYNC_POL=0 with H_* set to 2,2,4,2 and V_* set to 1,1,3,1 → hsync low for h=0..1, H_TOTAL=10, V_TOTAL=6, active for h=4..7 and v=2..4.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-timing generator for the VGA output path. One horizontal and one
//   vertical counter advance on a pixel enable. Every output is registered and
//   decoded from the next-count value, so the decodes line up with the counts
//   presented in the same cycle.
//
//   Line/frame order: sync, back porch, active, front porch, starting at 0.
//
// Ports
//   clk          clock (pixel clock, or faster with a divided enable)
//   rst_n        synchronous active-low reset
//   en           pixel enable; counters advance only when high
//   h_count      horizontal count, 0..H_TOTAL-1
//   v_count      vertical count, 0..V_TOTAL-1
//   hsync/vsync  SYNC_POL during the sync interval, ~SYNC_POL elsewhere
//   active       high inside the visible area
//   pixel_x/y    active-area coordinates, 0 outside the visible area
//   line_start   one-clk strobe after an enabled wrap into h_count=0
//   frame_start  one-clk strobe after an enabled wrap into (0,0)
module vga_timing_gen #(
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [15:0] h_count,
  output logic [15:0] v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_start,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_SYNC_W = 16'(H_SYNC);
  localparam logic [15:0] V_SYNC_W = 16'(V_SYNC);
  localparam logic [15:0] HA0      = 16'(H_SYNC + H_BP);
  localparam logic [15:0] HA1      = 16'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [15:0] VA0      = 16'(V_SYNC + V_BP);
  localparam logic [15:0] VA1      = 16'(V_SYNC + V_BP + V_ACTIVE);

  logic [15:0] h_count_q, h_count_d;
  logic [15:0] v_count_q, v_count_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        active_q, active_d;
  logic [9:0]  pixel_x_q, pixel_x_d;
  logic [9:0]  pixel_y_q, pixel_y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  logic        h_in, v_in;
  logic [15:0] px_full, py_full;

  always_comb begin
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (en) begin
      if (h_count_q == H_LAST) begin
        h_count_d     = '0;
        line_start_d  = 1'b1;
        frame_start_d = (v_count_q == V_LAST);
        v_count_d     = (v_count_q == V_LAST) ? 16'd0 : v_count_q + 16'd1;
      end else begin
        h_count_d = h_count_q + 16'd1;
      end
    end

    // Decode from the next counts so outputs and counts change together.
    h_in     = (h_count_d >= HA0) && (h_count_d < HA1);
    v_in     = (v_count_d >= VA0) && (v_count_d < VA1);
    active_d = h_in && v_in;

    px_full   = h_count_d - HA0;
    py_full   = v_count_d - VA0;
    pixel_x_d = active_d ? px_full[9:0] : 10'd0;
    pixel_y_d = active_d ? py_full[9:0] : 10'd0;

    hsync_d = (h_count_d < H_SYNC_W) ? SYNC_POL : ~SYNC_POL;
    vsync_d = (v_count_d < V_SYNC_W) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      hsync_q       <= SYNC_POL;
      vsync_q       <= SYNC_POL;
      active_q      <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_count     = h_count_q;
  assign v_count     = v_count_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  logic clk;
  logic rst_n_a, en_a, rst_n_b, en_b;

  logic [15:0] h_a, v_a, h_b, v_b;
  logic        hs_a, vs_a, act_a, ls_a, fs_a;
  logic        hs_b, vs_b, act_b, ls_b, fs_b;
  logic [9:0]  px_a, py_a, px_b, py_b;

  int n_cmp = 0;
  int n_err = 0;

  // Default 640x480 timing.
  vga_timing_gen u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .en(en_a),
    .h_count(h_a), .v_count(v_a), .hsync(hs_a), .vsync(vs_a),
    .active(act_a), .pixel_x(px_a), .pixel_y(py_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  // Tiny timing with negative sync: H_TOTAL=10, V_TOTAL=6.
  vga_timing_gen #(
    .H_SYNC(2), .H_BP(2), .H_ACTIVE(4), .H_FP(2),
    .V_SYNC(1), .V_BP(1), .V_ACTIVE(3), .V_FP(1),
    .SYNC_POL(1'b0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .en(en_b),
    .h_count(h_b), .v_count(v_b), .hsync(hs_b), .vsync(vs_b),
    .active(act_b), .pixel_x(px_b), .pixel_y(py_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input int n);
    en_a = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset;
    rst_n_a = 1'b0;
    en_a    = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if ({h_a, v_a} !== 32'd0) begin n_err++; $display("FAIL reset_counts: got h=%0d v=%0d, want 0 0", h_a, v_a); end
    n_cmp++; if ({hs_a, vs_a} !== 2'b11) begin n_err++; $display("FAIL reset_sync: got %b%b, want 11", hs_a, vs_a); end
    n_cmp++; if ({act_a, px_a, py_a} !== 21'd0) begin n_err++; $display("FAIL reset_active: got act=%0d px=%0d py=%0d, want 0", act_a, px_a, py_a); end
    n_cmp++; if ({ls_a, fs_a} !== 2'b00) begin n_err++; $display("FAIL reset_strobes: got %b%b, want 00", ls_a, fs_a); end
    rst_n_a = 1'b1;
    tick();
    n_cmp++; if ({h_a, v_a} !== {16'd1, 16'd0}) begin n_err++; $display("FAIL release_count: got h=%0d v=%0d, want 1 0", h_a, v_a); end
    n_cmp++; if ({ls_a, fs_a} !== 2'b00) begin n_err++; $display("FAIL release_strobes: got %b%b, want 00", ls_a, fs_a); end
  endtask

  task automatic test_hsync;
    int hs_cnt;
    run_a(799);  // (1,0) -> (0,1)
    n_cmp++; if ({h_a, v_a} !== {16'd0, 16'd1}) begin n_err++; $display("FAIL pos_line1: got h=%0d v=%0d, want 0 1", h_a, v_a); end
    n_cmp++; if (vs_a !== 1'b1) begin n_err++; $display("FAIL vsync_v1: got %b, want 1", vs_a); end
    hs_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (hs_a === 1'b1) hs_cnt++;
      if (i == 95) begin n_cmp++; if (hs_a !== 1'b1) begin n_err++; $display("FAIL hsync_h95: got %b, want 1", hs_a); end end
      if (i == 96) begin n_cmp++; if (hs_a !== 1'b0) begin n_err++; $display("FAIL hsync_h96: got %b, want 0", hs_a); end end
      tick();
    end
    n_cmp++; if (hs_cnt != 96) begin n_err++; $display("FAIL hsync_width: got %0d, want 96", hs_cnt); end
    n_cmp++; if ({h_a, v_a} !== {16'd0, 16'd2}) begin n_err++; $display("FAIL pos_line2: got h=%0d v=%0d, want 0 2", h_a, v_a); end
    n_cmp++; if (vs_a !== 1'b0) begin n_err++; $display("FAIL vsync_v2: got %b, want 0", vs_a); end
  endtask

  task automatic test_line_wrap;
    run_a(7199);  // (0,2) -> (799,10)
    n_cmp++; if ({h_a, v_a} !== {16'd799, 16'd10}) begin n_err++; $display("FAIL pos_799_10: got h=%0d v=%0d, want 799 10", h_a, v_a); end
    n_cmp++; if (ls_a !== 1'b0) begin n_err++; $display("FAIL ls_before_wrap: got %b, want 0", ls_a); end
    tick();
    n_cmp++; if ({h_a, v_a} !== {16'd0, 16'd11}) begin n_err++; $display("FAIL line_wrap: got h=%0d v=%0d, want 0 11", h_a, v_a); end
    n_cmp++; if ({ls_a, fs_a} !== 2'b10) begin n_err++; $display("FAIL line_wrap_strobes: got %b%b, want 10", ls_a, fs_a); end
    tick();
    n_cmp++; if ({h_a, ls_a} !== {16'd1, 1'b0}) begin n_err++; $display("FAIL line_strobe_end: got h=%0d ls=%b, want 1 0", h_a, ls_a); end
  endtask

  task automatic test_active_line;
    int act_cnt;
    run_a(19199);  // (1,11) -> (0,35)
    n_cmp++; if ({h_a, v_a} !== {16'd0, 16'd35}) begin n_err++; $display("FAIL pos_line35: got h=%0d v=%0d, want 0 35", h_a, v_a); end
    act_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (act_a === 1'b1) act_cnt++;
      if (i == 143) begin n_cmp++; if (act_a !== 1'b0) begin n_err++; $display("FAIL active_h143: got %b, want 0", act_a); end end
      if (i == 144) begin n_cmp++; if ({act_a, px_a, py_a} !== {1'b1, 10'd0, 10'd0}) begin n_err++; $display("FAIL active_h144: got act=%b px=%0d py=%0d, want 1 0 0", act_a, px_a, py_a); end end
      if (i == 783) begin n_cmp++; if ({act_a, px_a} !== {1'b1, 10'd639}) begin n_err++; $display("FAIL active_h783: got act=%b px=%0d, want 1 639", act_a, px_a); end end
      if (i == 784) begin n_cmp++; if ({act_a, px_a, py_a} !== 21'd0) begin n_err++; $display("FAIL active_h784: got act=%b px=%0d py=%0d, want 0 0 0", act_a, px_a, py_a); end end
      tick();
    end
    n_cmp++; if (act_cnt != 640) begin n_err++; $display("FAIL active_width: got %0d, want 640", act_cnt); end
    run_a(144);  // (0,36) -> (144,36)
    n_cmp++; if ({act_a, px_a, py_a} !== {1'b1, 10'd0, 10'd1}) begin n_err++; $display("FAIL pixel_y_row1: got act=%b px=%0d py=%0d, want 1 0 1", act_a, px_a, py_a); end
  endtask

  task automatic test_enable_gating;
    run_a(655);  // (144,36) -> (799,36)
    en_a = 1'b0;
    tick(); tick();
    n_cmp++; if ({h_a, v_a} !== {16'd799, 16'd36}) begin n_err++; $display("FAIL en_hold: got h=%0d v=%0d, want 799 36", h_a, v_a); end
    n_cmp++; if ({ls_a, hs_a, act_a} !== 3'b000) begin n_err++; $display("FAIL en_hold_levels: got ls=%b hs=%b act=%b, want 000", ls_a, hs_a, act_a); end
    en_a = 1'b1;
    tick();
    n_cmp++; if ({h_a, v_a, ls_a} !== {16'd0, 16'd37, 1'b1}) begin n_err++; $display("FAIL en_wrap: got h=%0d v=%0d ls=%b, want 0 37 1", h_a, v_a, ls_a); end
    en_a = 1'b0;
    tick();
    n_cmp++; if ({h_a, ls_a, hs_a} !== {16'd0, 1'b0, 1'b1}) begin n_err++; $display("FAIL en_strobe_once: got h=%0d ls=%b hs=%b, want 0 0 1", h_a, ls_a, hs_a); end
    tick();
    n_cmp++; if ({h_a, ls_a} !== {16'd0, 1'b0}) begin n_err++; $display("FAIL en_strobe_stays_low: got h=%0d ls=%b, want 0 0", h_a, ls_a); end
    en_a = 1'b1;
    tick();
    n_cmp++; if ({h_a, v_a} !== {16'd1, 16'd37}) begin n_err++; $display("FAIL en_resume: got h=%0d v=%0d, want 1 37", h_a, v_a); end
  endtask

  task automatic test_midframe_reset;
    run_a(2699);  // (1,37) -> (300,40)
    n_cmp++; if ({h_a, v_a, act_a, px_a, py_a} !== {16'd300, 16'd40, 1'b1, 10'd156, 10'd5}) begin n_err++; $display("FAIL pos_300_40: got h=%0d v=%0d act=%b px=%0d py=%0d, want 300 40 1 156 5", h_a, v_a, act_a, px_a, py_a); end
    rst_n_a = 1'b0;
    tick();
    n_cmp++; if ({h_a, v_a, hs_a, vs_a, act_a, px_a, py_a, ls_a, fs_a} !== {32'd0, 2'b11, 1'b0, 20'd0, 2'b00}) begin n_err++; $display("FAIL midframe_reset: got h=%0d v=%0d hs=%b vs=%b act=%b px=%0d py=%0d ls=%b fs=%b", h_a, v_a, hs_a, vs_a, act_a, px_a, py_a, ls_a, fs_a); end
    rst_n_a = 1'b1;
    tick();
    n_cmp++; if ({h_a, v_a, ls_a} !== {16'd1, 16'd0, 1'b0}) begin n_err++; $display("FAIL midframe_release: got h=%0d v=%0d ls=%b, want 1 0 0", h_a, v_a, ls_a); end
  endtask

  // Small-parameter instance: reset values, then two full frames
  // against a position-based expectation.
  task automatic test_alt_params;
    int eh, ev, last_fs;
    logic e_act;
    logic [56:0] got_v, exp_v;
    rst_n_b = 1'b0;
    en_b    = 1'b1;
    tick(); tick();
    n_cmp++; if ({h_b, v_b, hs_b, vs_b, act_b, ls_b, fs_b} !== {32'd0, 2'b00, 3'b000}) begin n_err++; $display("FAIL alt_reset: got h=%0d v=%0d hs=%b vs=%b act=%b ls=%b fs=%b", h_b, v_b, hs_b, vs_b, act_b, ls_b, fs_b); end
    rst_n_b = 1'b1;
    last_fs = -1;
    for (int p = 1; p <= 130; p++) begin
      tick();
      eh    = p % 10;
      ev    = (p / 10) % 6;
      e_act = (eh >= 4) && (eh < 8) && (ev >= 2) && (ev < 5);
      exp_v = {16'(eh), 16'(ev), (eh >= 2), (ev >= 1), e_act,
               e_act ? 10'(eh - 4) : 10'd0, e_act ? 10'(ev - 2) : 10'd0,
               (eh == 0), (eh == 0) && (ev == 0)};
      got_v = {h_b, v_b, hs_b, vs_b, act_b, px_b, py_b, ls_b, fs_b};
      n_cmp++;
      if (got_v !== exp_v) begin
        n_err++;
        $display("FAIL alt_frame p=%0d: got h=%0d v=%0d hs=%b vs=%b act=%b px=%0d py=%0d ls=%b fs=%b, want %h",
                 p, h_b, v_b, hs_b, vs_b, act_b, px_b, py_b, ls_b, fs_b, exp_v);
      end
      if (fs_b === 1'b1) begin
        if (last_fs >= 0) begin
          n_cmp++; if (p - last_fs != 60) begin n_err++; $display("FAIL alt_frame_period: got %0d, want 60", p - last_fs); end
        end
        last_fs = p;
      end
    end
    n_cmp++; if (last_fs != 120) begin n_err++; $display("FAIL alt_last_frame_start: got %0d, want 120", last_fs); end
  endtask

  initial begin
    rst_n_a = 1'b0; en_a = 1'b0;
    rst_n_b = 1'b0; en_b = 1'b0;
    test_reset();
    test_hsync();
    test_line_wrap();
    test_active_line();
    test_enable_gating();
    test_midframe_reset();
    test_alt_params();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
